// File: rtl/pf_ddr4_c0_ddrphy_blk_iod_rx_bitslip_align.sv
// Receive word aligner for a 4:1 IOD lane: slips the deserializer until the training pattern is seen MATCH_COUNT times in a row.
// RX_DATA_OUT is RX_DATA_IN delayed one cycle; status and slip pulse are registered.
module pf_ddr4_c0_ddrphy_blk_iod_rx_bitslip_align #(
  parameter logic [3:0]  TRAIN_PATTERN = 4'b0011,
  parameter int unsigned MATCH_COUNT   = 8,
  parameter int unsigned SLIP_WAIT     = 4,
  parameter int unsigned MAX_SLIPS     = 3
) (
  input  logic       FAB_CLK,
  input  logic       RX_SYNC_RST,
  input  logic       ALIGN_START,
  input  logic [3:0] RX_DATA_IN,
  output logic       RX_BIT_SLIP,
  output logic       LOCKED,
  output logic       ALIGN_DONE,
  output logic       ALIGN_FAIL,
  output logic [2:0] SLIP_CNT,
  output logic [3:0] RX_DATA_OUT,
  output logic       RX_DATA_VALID
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_SLIP  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_LOCK  = 3'd4;
  localparam logic [2:0] ST_FAIL  = 3'd5;

  localparam logic [7:0] MATCH_TGT = 8'(MATCH_COUNT);
  localparam logic [3:0] WAIT_LD   = 4'(SLIP_WAIT);
  localparam logic [2:0] SLIP_MAX  = 3'(MAX_SLIPS);

  logic [2:0] state, state_nxt;
  logic [7:0] match_cnt, match_nxt, match_inc;
  logic [3:0] wait_cnt, wait_nxt;
  logic [2:0] slip_cnt, slip_nxt;
  logic       bit_slip_nxt;
  logic       locked, locked_nxt;
  logic       done, done_nxt;
  logic       fail, fail_nxt;
  logic [3:0] data_q;

  assign match_inc = 8'(match_cnt + 8'd1);

  always_comb begin
    state_nxt    = state;
    match_nxt    = match_cnt;
    wait_nxt     = wait_cnt;
    slip_nxt     = slip_cnt;
    bit_slip_nxt = 1'b0;
    locked_nxt   = locked;
    done_nxt     = 1'b0;
    fail_nxt     = fail;

    // A start request overrides whatever the FSM would otherwise do this cycle.
    if (ALIGN_START) begin
      state_nxt  = ST_CHECK;
      match_nxt  = 8'd0;
      slip_nxt   = 3'd0;
      locked_nxt = 1'b0;
      fail_nxt   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_IDLE;
        end
        ST_CHECK: begin
          if (RX_DATA_IN == TRAIN_PATTERN) begin
            match_nxt = match_inc;
            if (match_inc == MATCH_TGT) begin
              state_nxt  = ST_LOCK;
              locked_nxt = 1'b1;
              done_nxt   = 1'b1;
            end
          end else begin
            match_nxt = 8'd0;
            if (slip_cnt < SLIP_MAX) begin
              state_nxt    = ST_SLIP;
              bit_slip_nxt = 1'b1;
              slip_nxt     = (slip_cnt == 3'd7) ? 3'd7 : 3'(slip_cnt + 3'd1);
            end else begin
              state_nxt = ST_FAIL;
              fail_nxt  = 1'b1;
            end
          end
        end
        ST_SLIP: begin
          wait_nxt  = WAIT_LD;
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          // Data is ignored here while the IOD settles on the new boundary.
          if (wait_cnt <= 4'd1) begin
            wait_nxt  = 4'd0;
            match_nxt = 8'd0;
            state_nxt = ST_CHECK;
          end else begin
            wait_nxt = 4'(wait_cnt - 4'd1);
          end
        end
        ST_LOCK: begin
          state_nxt = ST_LOCK;
        end
        ST_FAIL: begin
          state_nxt = ST_FAIL;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      state       <= ST_IDLE;
      match_cnt   <= 8'd0;
      wait_cnt    <= 4'd0;
      slip_cnt    <= 3'd0;
      RX_BIT_SLIP <= 1'b0;
      locked      <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      data_q      <= 4'd0;
    end else begin
      state       <= state_nxt;
      match_cnt   <= match_nxt;
      wait_cnt    <= wait_nxt;
      slip_cnt    <= slip_nxt;
      RX_BIT_SLIP <= bit_slip_nxt;
      locked      <= locked_nxt;
      done        <= done_nxt;
      fail        <= fail_nxt;
      data_q      <= RX_DATA_IN;
    end
  end

  assign LOCKED        = locked;
  assign ALIGN_DONE    = done;
  assign ALIGN_FAIL    = fail;
  assign SLIP_CNT      = slip_cnt;
  assign RX_DATA_OUT   = data_q;
  assign RX_DATA_VALID = locked;

endmodule

// File: tb/tb_pf_ddr4_c0_ddrphy_blk_iod_rx_bitslip_align.sv
// Bench for the RX bitslip aligner: an IOD lane model that rotates on each slip pulse, directed scenarios and randomized lane phases.
module tb_pf_ddr4_c0_ddrphy_blk_iod_rx_bitslip_align;

  localparam logic [3:0] PAT = 4'b0011;
  localparam int MC = 8;
  localparam int SW = 4;
  localparam int MS = 3;

  logic       FAB_CLK = 1'b0;
  logic       RX_SYNC_RST;
  logic       ALIGN_START;
  logic [3:0] RX_DATA_IN;

  logic       bit_slip, locked, align_done, align_fail, data_valid;
  logic [2:0] slip_cnt;
  logic [3:0] data_out;
  logic       z_bit_slip, z_locked, z_align_done, z_align_fail, z_data_valid;
  logic [2:0] z_slip_cnt;
  logic [3:0] z_data_out;

  pf_ddr4_c0_ddrphy_blk_iod_rx_bitslip_align #(
    .TRAIN_PATTERN(PAT), .MATCH_COUNT(MC), .SLIP_WAIT(SW), .MAX_SLIPS(MS)
  ) dut (
    .FAB_CLK(FAB_CLK), .RX_SYNC_RST(RX_SYNC_RST), .ALIGN_START(ALIGN_START),
    .RX_DATA_IN(RX_DATA_IN), .RX_BIT_SLIP(bit_slip), .LOCKED(locked),
    .ALIGN_DONE(align_done), .ALIGN_FAIL(align_fail), .SLIP_CNT(slip_cnt),
    .RX_DATA_OUT(data_out), .RX_DATA_VALID(data_valid)
  );

  // Same lane, but no slips allowed.
  pf_ddr4_c0_ddrphy_blk_iod_rx_bitslip_align #(
    .TRAIN_PATTERN(PAT), .MATCH_COUNT(MC), .SLIP_WAIT(SW), .MAX_SLIPS(0)
  ) dut_z (
    .FAB_CLK(FAB_CLK), .RX_SYNC_RST(RX_SYNC_RST), .ALIGN_START(ALIGN_START),
    .RX_DATA_IN(RX_DATA_IN), .RX_BIT_SLIP(z_bit_slip), .LOCKED(z_locked),
    .ALIGN_DONE(z_align_done), .ALIGN_FAIL(z_align_fail), .SLIP_CNT(z_slip_cnt),
    .RX_DATA_OUT(z_data_out), .RX_DATA_VALID(z_data_valid)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int off = 0;
  int mode = 0;
  logic [3:0] const_word = 4'd0;
  int glitch_cyc = -1;
  bit follow = 1'b1;
  logic [3:0] prev_in;
  logic prev_rst;
  logic prev_slip = 1'b0;
  int pulses[$];
  int lock_first, done_n, done_cyc, fail_first, z_pulse_n, z_fail_first;

  function automatic logic [3:0] rot(input logic [3:0] w, input int k);
    logic [7:0] d;
    d = {w, w};
    return d[k +: 4];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    if (cyc == glitch_cyc) RX_DATA_IN = 4'b1111;
    else if (mode == 0)    RX_DATA_IN = rot(PAT, off);
    else if (mode == 1)    RX_DATA_IN = const_word;
    else                   RX_DATA_IN = 4'($urandom);
  endtask

  task automatic clear_obs();
    pulses.delete();
    lock_first   = -1;
    done_n       = 0;
    done_cyc     = -1;
    fail_first   = -1;
    z_pulse_n    = 0;
    z_fail_first = -1;
  endtask

  task automatic tick();
    prev_in  = RX_DATA_IN;
    prev_rst = RX_SYNC_RST;
    @(posedge FAB_CLK);
    #1;
    cyc++;
    check("data_out", 32'(data_out), prev_rst ? 32'd0 : 32'(prev_in));
    check("slip_back_to_back", 32'(prev_slip & bit_slip), 32'd0);
    prev_slip = bit_slip;
    if (bit_slip) begin
      pulses.push_back(cyc);
      if (follow) off = (off + 1) % 4;
    end
    if (locked && lock_first < 0) lock_first = cyc;
    if (align_done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (align_fail && fail_first < 0) fail_first = cyc;
    if (z_bit_slip) z_pulse_n++;
    if (z_align_fail && z_fail_first < 0) z_fail_first = cyc;
    drive_data();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic start(output int e0);
    clear_obs();
    ALIGN_START = 1'b1;
    e0 = cyc + 1;
    tick();
    ALIGN_START = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_slip"},   32'(bit_slip),   32'd0);
    check({tag, "_locked"}, 32'(locked),     32'd0);
    check({tag, "_done"},   32'(align_done), 32'd0);
    check({tag, "_fail"},   32'(align_fail), 32'd0);
    check({tag, "_cnt"},    32'(slip_cnt),   32'd0);
    check({tag, "_valid"},  32'(data_valid), 32'd0);
  endtask

  // Outcome of an attempt from a lane phase, derived from the timing rules:
  // each slip costs SW+2 compare slots, lock needs MC consecutive matches.
  task automatic predict(input string tag, input int e0, input int off0);
    int n, k;
    n = (4 - off0) % 4;
    k = (n <= MS) ? n : MS;
    check({tag, "_npulses"}, pulses.size(), k);
    for (int i = 0; i < k; i++)
      if (i < pulses.size()) check({tag, "_pulse_t"}, pulses[i], e0 + 1 + i * (SW + 2));
    if (n <= MS) begin
      check({tag, "_lock_t"}, lock_first, e0 + n * (SW + 2) + MC);
      check({tag, "_done_n"}, done_n, 1);
      check({tag, "_done_t"}, done_cyc, e0 + n * (SW + 2) + MC);
      check({tag, "_valid"}, 32'(data_valid), 32'd1);
      check({tag, "_fail"}, 32'(align_fail), 32'd0);
      check({tag, "_cnt"}, 32'(slip_cnt), n);
    end else begin
      check({tag, "_fail_t"}, fail_first, e0 + 1 + MS * (SW + 2));
      check({tag, "_locked"}, 32'(locked), 32'd0);
      check({tag, "_cnt"}, 32'(slip_cnt), MS);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, off0;
    RX_SYNC_RST = 1'b1;
    ALIGN_START = 1'b0;
    RX_DATA_IN  = PAT;
    clear_obs();

    // Reset state, and reset beating a simultaneous start.
    run(3);
    check_zero("reset");
    ALIGN_START = 1'b1;
    tick();
    check_zero("rst_and_start");
    ALIGN_START = 1'b0;
    RX_SYNC_RST = 1'b0;
    clear_obs();
    run(MC + 4);
    check("idle_no_lock", lock_first, -1);
    check("idle_no_pulse", pulses.size(), 0);

    // Aligned lane.
    off = 0; mode = 0;
    start(e0);
    run(MC + 4);
    predict("aligned", e0, 0);
    check("aligned_done_low", 32'(align_done), 32'd0);

    // Two rotations off.
    off = 2;
    start(e0);
    run(40);
    predict("two_slip", e0, 2);
    if (pulses.size() >= 2) check("two_slip_gap", pulses[1] - pulses[0] - 1, SW + 1);

    // Unalignable lane.
    mode = 1; const_word = 4'b0000;
    start(e0);
    run(40);
    check("unalign_npulses", pulses.size(), MS);
    check("unalign_fail_t", fail_first, e0 + 1 + MS * (SW + 2));
    check("unalign_cnt", 32'(slip_cnt), MS);
    check("unalign_locked", 32'(locked), 32'd0);
    run(20);
    check("unalign_fail_held", 32'(align_fail), 32'd1);
    start(e0);
    check("unalign_fail_clear", 32'(align_fail), 32'd0);

    // Single corrupted word after five good matches; lane itself stays aligned.
    mode = 0; off = 0; follow = 1'b0;
    start(e0);
    glitch_cyc = e0 + 5;
    run(30);
    check("glitch_npulses", pulses.size(), 1);
    if (pulses.size() >= 1) check("glitch_pulse_t", pulses[0], e0 + 6);
    check("glitch_lock_t", lock_first, e0 + 6 + SW + 1 + MC);
    check("glitch_cnt", 32'(slip_cnt), 32'd1);
    check("glitch_ms0_fail_t", z_fail_first, e0 + 6);
    check("glitch_ms0_pulses", z_pulse_n, 0);
    check("glitch_ms0_cnt", 32'(z_slip_cnt), 32'd0);
    glitch_cyc = -1; follow = 1'b1;

    // Reset two cycles after a slip pulse.
    off = 2;
    start(e0);
    run(1);
    check("midwait_pulse", 32'(bit_slip), 32'd1);
    run(2);
    RX_SYNC_RST = 1'b1;
    tick();
    RX_SYNC_RST = 1'b0;
    check_zero("midwait_reset");
    clear_obs();
    run(30);
    check("midwait_no_pulse", pulses.size(), 0);
    check("midwait_no_lock", lock_first, -1);
    check("midwait_no_fail", fail_first, -1);

    // Restart from LOCK, with mission data in between.
    off = 0;
    start(e0);
    run(MC + 2);
    check("lock_before_mission", 32'(locked), 32'd1);
    mode = 2;
    run(20);
    check("lock_through_mission", 32'(locked), 32'd1);
    mode = 0;
    start(e1);
    check("restart_locked_drop", 32'(locked), 32'd0);
    check("restart_cnt", 32'(slip_cnt), 32'd0);
    run(MC + 3);
    check("restart_lock_t", lock_first, e1 + MC);
    check("restart_done_n", done_n, 1);

    // Start coinciding with the final match: restart wins.
    start(e0);
    run(MC - 1);
    start(e1);
    check("race_e1", e1, e0 + MC);
    check("race_no_lock", 32'(locked), 32'd0);
    check("race_no_done", 32'(align_done), 32'd0);
    run(MC + 3);
    check("race_lock_t", lock_first, e1 + MC);
    check("race_done_n", done_n, 1);

    // Randomized lane phases.
    for (int t = 0; t < 10; t++) begin
      off0 = int'($urandom_range(0, 3));
      off = off0; mode = 0;
      start(e0);
      run(40);
      predict("rand", e0, off0);
      mode = 2;
      run(int'($urandom_range(1, 10)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
